// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Drives the port select, captures the returned word and hands it back with a one-cycle pulse.
module regfile_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  output logic [ADDR_W-1:0]      rd_select_o,
  input  logic [DATA_W-1:0]      rd_data_i,
  output logic [NREQ-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]      resp_data_o,
  output logic [NREQ-1:0]        grant_o,
  output logic                   busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0]   rd_select_q, rd_select_d;
  logic [NREQ-1:0]     resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [NREQ-1:0]     cand;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [NREQ-1:0]     win_onehot;
  logic [PTR_W-1:0]    owner_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // In DONE the current winner still holds req, so it is masked out of the next round.
  always_comb begin
    cand = req_i;
    if (state_q == DONE) begin
      cand = req_i & ~grant_q;
    end
  end

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    logic [PTR_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + PTR_W'(k);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_onehot = NREQ'(1) << win_idx;

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        owner_idx = PTR_W'(k);
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rd_select_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rd_select_q  <= rd_select_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = win_found ? READ : IDLE;
      READ: state_d = DONE;
      DONE: state_d = win_found ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    grant_d      = grant_q;
    rd_select_d  = rd_select_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    rr_ptr_d     = rr_ptr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (win_found) begin
          grant_d     = win_onehot;
          rd_select_d = addr_arr[win_idx];
        end else begin
          grant_d     = '0;
        end
      end
      READ: begin
        resp_data_d  = rd_data_i;
        resp_valid_d = grant_q;
        rr_ptr_d     = owner_idx + PTR_W'(1);
      end
      default: begin
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign rd_select_o  = rd_select_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random requesters,
// all checked against a transaction-level model of the shared read port.
module tb_regfile_read_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [19:0] req_addr_i = '0;
  logic [4:0]  rd_select_o;
  logic [31:0] rd_data_i;
  logic [3:0]  resp_valid_o;
  logic [31:0] resp_data_o;
  logic [3:0]  grant_o;
  logic        busy_o;

  regfile_read_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .rd_select_o (rd_select_o),
    .rd_data_i   (rd_data_i),
    .resp_valid_o(resp_valid_o),
    .resp_data_o (resp_data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [32];
  always_comb rd_data_i = mem[rd_select_o];

  int tests = 0;
  int fails = 0;

  // Port model: who owns the port, and whether its data is due at the next edge.
  int          m_owner;
  bit          m_fresh;
  int          m_ptr;
  logic [4:0]  m_sel;
  logic [3:0]  m_resp;
  logic [31:0] m_data;
  logic [3:0]  last_drop;
  int          waitc [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] cand, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (cand[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic mreset();
    m_owner = -1; m_fresh = 0; m_ptr = 0; m_sel = '0; m_resp = '0; m_data = '0;
    last_drop = '0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
  endtask

  // A granted owner gets its data on the following edge; the port is then free again
  // at the edge after that, where the responding requester is not eligible.
  task automatic model_edge(input logic [3:0] rq, input logic [19:0] ad);
    logic [3:0] cand;
    int w;
    m_resp = '0;
    if (m_owner >= 0 && m_fresh) begin
      m_resp  = 4'(1 << m_owner);
      m_data  = mem[m_sel];
      m_ptr   = (m_owner + 1) % 4;
      m_fresh = 0;
    end else begin
      cand = rq;
      if (m_owner >= 0) cand[m_owner] = 1'b0;
      w = rr_pick(cand, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_fresh = 1;
        m_sel   = ad[w*5 +: 5];
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    logic [3:0]  rq;
    logic [19:0] ad;
    logic [3:0]  rv;
    rq = req_i; ad = req_addr_i; rv = resp_valid_o;
    @(posedge clk_i); #1;
    model_edge(rq, ad);
    for (int i = 0; i < 4; i++) if (rq[i]) waitc[i]++;
    chk("grant", grant_o, (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    chk("rd_select", rd_select_o, m_sel);
    chk("resp_valid", resp_valid_o, m_resp);
    chk("busy", busy_o, (m_owner >= 0) ? 1 : 0);
    if (m_resp != 0) chk("resp_data", resp_data_o, m_data);
    chk("grant_onehot0", $onehot0(grant_o), 1);
    chk("resp_onehot0", $onehot0(resp_valid_o), 1);
    chk("resp_repeat", rv & resp_valid_o, 0);
    // Requester rule: drop req on the edge where its resp_valid bit was sampled high.
    req_i     = req_i & ~rv;
    last_drop = rv;
    $display("[TB] t=%0t req=%b grant=%b sel=%0d resp=%b data=%h busy=%b",
             $time, rq, grant_o, rd_select_o, resp_valid_o, resp_data_o, busy_o);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    #1 mreset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  logic [3:0]  seq_resp [$];
  logic [31:0] seq_data [$];
  int          seq_tick [$];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    mreset();
    #1;
    chk("reset_grant", grant_o, 0);
    chk("reset_sel", rd_select_o, 0);
    chk("reset_resp", resp_valid_o, 0);
    chk("reset_data", resp_data_o, 0);
    chk("reset_busy", busy_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Single request from requester 0, address 5.
    req_addr_i[4:0] = 5'd5;
    req_i = 4'b0001;
    tick();
    chk("t1_sel", rd_select_o, 5);
    chk("t1_busy_a", busy_o, 1);
    tick();
    chk("t1_resp", resp_valid_o, 4'b0001);
    chk("t1_data", resp_data_o, 32'h105);
    chk("t1_busy_b", busy_o, 1);
    tick();
    chk("t1_grant_idle", grant_o, 0);
    chk("t1_busy_idle", busy_o, 0);

    // All four contend continuously, addresses 1..4.
    do_reset();
    req_addr_i = {5'd4, 5'd3, 5'd2, 5'd1};
    req_i = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (resp_valid_o != 0) begin
        seq_resp.push_back(resp_valid_o);
        seq_data.push_back(resp_data_o);
        seq_tick.push_back(t);
      end
      req_i = req_i | ~last_drop;
    end
    chk("t2_count", seq_resp.size(), 5);
    for (int k = 0; k < 5 && k < seq_resp.size(); k++) begin
      chk("t2_order", seq_resp[k], 32'(1 << (k % 4)));
      chk("t2_data", seq_data[k], 32'h101 + 32'(k % 4));
      chk("t2_spacing", seq_tick[k], 2 * k + 2);
    end
    while (req_i != 0 || busy_o) begin
      req_i = '0;
      tick();
    end

    // Pointer advances past requester 1, so requester 0 wins the next round.
    do_reset();
    req_addr_i = {5'd0, 5'd0, 5'd9, 5'd6};
    req_i = 4'b0010;
    tick(); tick(); tick(); tick();
    req_i = 4'b0011;
    tick();
    chk("t3_grant0", grant_o, 4'b0001);
    tick();
    chk("t3_resp0", resp_valid_o, 4'b0001);
    chk("t3_data0", resp_data_o, 32'h106);
    tick();
    chk("t3_grant1", grant_o, 4'b0010);
    tick();
    chk("t3_data1", resp_data_o, 32'h109);
    tick(); tick();

    // New request arriving during DONE starts the next READ with no idle cycle.
    do_reset();
    req_addr_i = {5'd31, 5'd0, 5'd2, 5'd0};
    req_i = 4'b0100;
    tick();
    tick();
    chk("t4_resp2", resp_valid_o, 4'b0100);
    req_i[3] = 1'b1;
    tick();
    chk("t4_grant3", grant_o, 4'b1000);
    chk("t4_sel31", rd_select_o, 31);
    chk("t4_busy", busy_o, 1);
    tick();
    chk("t4_resp3", resp_valid_o, 4'b1000);
    chk("t4_data3", resp_data_o, 32'h11F);
    tick(); tick();

    // Reset asserted mid-READ discards the access; held request is re-served.
    do_reset();
    req_addr_i = {5'd0, 5'd0, 5'd0, 5'd7};
    req_i = 4'b0001;
    tick();
    #2 rst_i = 1'b1;
    #1;
    chk("t5_grant_clr", grant_o, 0);
    chk("t5_sel_clr", rd_select_o, 0);
    chk("t5_resp_clr", resp_valid_o, 0);
    chk("t5_data_clr", resp_data_o, 0);
    chk("t5_busy_clr", busy_o, 0);
    mreset();
    @(posedge clk_i); #1;
    chk("t5_resp_held", resp_valid_o, 0);
    rst_i = 1'b0;
    tick();
    chk("t5_regrant", grant_o, 4'b0001);
    tick();
    chk("t5_resp", resp_valid_o, 4'b0001);
    chk("t5_data", resp_data_o, 32'h107);
    tick(); tick();

    // Random requesters against random register contents.
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_i[i] && !last_drop[i] && ($urandom % 3 == 0)) begin
          req_addr_i[i*5 +: 5] = 5'($urandom);
          req_i[i] = 1'b1;
          waitc[i] = 0;
        end else if (req_i[i] && m_owner != i && ($urandom % 16 == 0)) begin
          req_i[i] = 1'b0;
          waitc[i] = 0;
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (resp_valid_o[i]) begin
          chk("rand_wait_bound", (waitc[i] <= 12) ? 1 : 0, 1);
          waitc[i] = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares one 32-entry decoded/tristate register-file read port among 4 requesters, e.g. CPU debug read, VGA board renderer, game-logic neighbour counter, and spare.
- Round-robin arbitration: grants one requester, drives the port's 5-bit select, captures the port's 32-bit output, and returns it to the winner with a one-cycle valid pulse.
- Sits between the requesting blocks and the read-port mux; owns that mux's select input exclusively.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 in this revision, RTL may hardcode.
- ADDR_W, 5, register index width; must match the read-port select width.
- DATA_W, 32, register data width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester read request; level, held until the matching resp_valid bit is sampled.
- req_addr  input  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]; must stay stable while req[i] is high.
- rd_select  output  ADDR_W  to read-port mux select (registered).
- rd_data  input  DATA_W  from read-port mux output; combinational function of rd_select.
- resp_valid  output  NREQ  one-hot, one-cycle pulse: data for requester i is ready.
- resp_data  output  DATA_W  captured register value; valid while any resp_valid bit is high.
- grant  output  NREQ  one-hot current owner of the port; 0 when idle.
- busy  output  1  high in READ or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE, rd_select=0, resp_data=0, resp_valid=0, grant=0, rr_ptr=0, busy=0. Any in-flight transaction is discarded with no response. Requesters still holding req are re-served after reset deasserts.
- FSM states: IDLE, READ, DONE. All outputs are registered.
- Arbitration function: among candidate req bits, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo 4.
- IDLE:
  - If any req bit is set: grant ← winner one-hot; rd_select ← winner's addr; go to READ.
  - Else stay in IDLE; rd_select holds its last value.
- READ: resp_data ← rd_data; resp_valid ← grant; rr_ptr ← winner+1 (mod 4); go to DONE. rd_select is stable throughout READ.
- DONE (resp_valid high this cycle):
  - Candidates are the req bits excluding the current winner, because the winner's req is still high in this cycle.
  - If any candidate: new grant, rd_select ← its addr, go to READ (back-to-back).
  - Else: grant ← 0, go to IDLE.
  - resp_valid returns to 0 on the next edge unconditionally.
- Requester rule: deassert req[i] on the edge where resp_valid[i] is sampled high. Re-asserting req[i] in the following cycle is legal and is arbitrated normally.
- Latency: req sampled at edge E0 → rd_select valid after E0 → rd_data captured at E1 → resp_valid/resp_data high between E1 and E2. That is 2 cycles request-to-response.
- Throughput: one access per 2 cycles under continuous contention.
- Fairness: with all 4 requesting continuously, grant order is 0,1,2,3,0,… and no requester waits more than 4 grants.
- Simultaneous events:
  - A new req arriving in DONE is eligible immediately.
  - A req dropping while not granted is legal; the arbiter never grants a bit that is low at sampling.
- Only one grant bit and at most one resp_valid bit is ever high.
- Address 0 is arbitrated like any other address; the read-port mux determines its value.

Test Plan:
- Reset, then req=0001 with addr0=5 and rd_data model = 0x100+select → rd_select=5 after 1 cycle; resp_valid=0001 and resp_data=0x105 after 2 cycles; busy 1 for 2 cycles; grant returns to 0.
- req=1111 held continuously (each requester dropping/re-raising per rule), addrs 1,2,3,4 → resp_valid sequence 0001,0010,0100,1000,0001 every 2 cycles; resp_data 0x101,0x102,0x103,0x104.
- rr_ptr=2 after serving requester 1, then req=0011 → requester 0 served before requester 1 is re-served only if requester 1 re-requests; verify grant=0001 next.
- In DONE for requester 2, raise req[3] with addr 31 → READ starts without an IDLE cycle; resp_valid=1000 and resp_data=0x11F two cycles after the previous pulse.
- Assert reset during READ → resp_valid stays 0 and all outputs clear immediately; after release with req still high, the transaction reissues and completes in 2 cycles.
- Assertions throughout: grant and resp_valid are one-hot-or-zero; resp_valid is never high for 2 consecutive cycles on the same bit; rd_select is stable whenever state=READ.
